uart_parity_engine: RTL and testbench

UART_PARITY_ENGINE -- requirements
Module: uart_parity_engine

---
 rtl/uart_parity_engine.sv | 146 ++++++++++++++
 tb/tb_uart_parity_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_engine.sv
// Parity generator/checker for a UART receive path. Tracks one frame at a time:
// accumulates parity over a DATA_W-bit data field (LSB first), then compares it
// against the received parity bit, and counts mismatches in a saturating counter.
module uart_parity_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       parity_type,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             par_valid,
  input  logic             par_in,
  input  logic             err_clr,
  output logic             busy,
  output logic             parity_bit,
  output logic             done,
  output logic             parity_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  localparam logic [2:0] ModeOdd   = 3'b001;
  localparam logic [2:0] ModeEven  = 3'b010;
  localparam logic [2:0] ModeMark  = 3'b011;
  localparam logic [2:0] ModeSpace = 3'b100;

  typedef enum logic [1:0] {StIdle, StData, StPar, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             acc_q, acc_d;
  logic             par_q, par_d;
  logic             mism_q, mism_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             has_parity;
  logic             acc_next;
  logic             par_expected;

  // Codes 101-111 fall through to "none", so parity exists only for the four named modes.
  assign has_parity = (mode_q == ModeOdd) || (mode_q == ModeEven) ||
                      (mode_q == ModeMark) || (mode_q == ModeSpace);

  assign acc_next = acc_q ^ bit_in;

  // Expected parity once the final data bit has been folded in.
  always_comb begin
    case (mode_q)
      ModeOdd, ModeEven: par_expected = acc_next;
      ModeMark:          par_expected = 1'b1;
      ModeSpace:         par_expected = 1'b0;
      default:           par_expected = 1'b1;
    endcase
  end

  // Next-state and datapath updates for the frame FSM and error counter.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    par_d     = par_q;
    mism_d    = mism_q;

    unique case (state_q)
      StIdle: begin
        // abort beats start; mismatch cleared so none-mode frames report no error
        if (start && !abort) begin
          mode_d    = parity_type;
          bit_cnt_d = '0;
          acc_d     = (parity_type == ModeOdd);
          mism_d    = 1'b0;
          state_d   = StData;
        end
      end
      StData: begin
        if (abort) begin
          state_d = StIdle;
        end else if (bit_valid) begin
          acc_d     = acc_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            par_d   = par_expected;
            state_d = has_parity ? StPar : StDone;
          end
        end
      end
      StPar: begin
        if (abort) begin
          state_d = StIdle;
        end else if (par_valid) begin
          mism_d  = (par_in != par_q);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    parity_err = done && mism_q && has_parity;

    // Clear wins over a coincident increment; the counter sticks at all-ones.
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (parity_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      bit_cnt_q <= '0;
      acc_q     <= 1'b0;
      par_q     <= 1'b1;
      mism_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
      par_q     <= par_d;
      mism_q    <= mism_d;
      cnt_q     <= cnt_d;
    end
  end

  assign parity_bit = par_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed bench for uart_parity_engine (DATA_W=8, CNT_W=2). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_uart_parity_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] parity_type;
  logic       start, abort, bit_valid, bit_in, par_valid, par_in, err_clr;
  logic       busy, parity_bit, done, parity_err;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;

  uart_parity_engine #(.DATA_W(8), .CNT_W(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .parity_type (parity_type),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .par_valid   (par_valid),
    .par_in      (par_in),
    .err_clr     (err_clr),
    .busy        (busy),
    .parity_bit  (parity_bit),
    .done        (done),
    .parity_err  (parity_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a frame and shift in n data bits, with an optional idle gap before each bit.
  task automatic frame_bits(input logic [2:0] mode, input logic [7:0] data, input int n,
                            input bit gaps);
    parity_type = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    parity_type = ~mode;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bit_valid = 1'b0;
        bit_in    = ~data[i];
        tick();
      end
      bit_valid = 1'b1;
      bit_in    = data[i];
      tick();
    end
    bit_valid = 1'b0;
  endtask

  // Deliver the parity bit and check the done cycle.
  task automatic par_phase(input string tag, input logic pin, input logic exp_pbit,
                           input logic exp_err);
    chk({tag, "_pre_done"}, done, 1'b0);
    par_valid = 1'b1;
    par_in    = pin;
    tick();
    par_valid = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_pbit"}, parity_bit, exp_pbit);
    chk({tag, "_perr"}, parity_err, exp_err);
  endtask

  initial begin
    reset_n = 1'b0; parity_type = 3'b000; start = 1'b1; abort = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0; par_valid = 1'b0; par_in = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_pbit", parity_bit, 1'b1);
    chk("rst_cnt", err_count, 2'd0);
    start = 1'b0;
    reset_n = 1'b1;
    tick();

    // Even, 0x55, par_in=0: no error; bit gaps exercise hold behaviour.
    frame_bits(3'b010, 8'h55, 8, 1'b1);
    chk("even_busy_par", busy, 1'b1);
    par_phase("even", 1'b0, 1'b0, 1'b0);
    tick();
    chk("even_idle", busy, 1'b0);
    chk("even_done_low", done, 1'b0);
    chk("even_cnt", err_count, 2'd0);

    // Odd, 0x55, par_in=0: expected 1, so mismatch.
    frame_bits(3'b001, 8'h55, 8, 1'b0);
    par_phase("odd", 1'b0, 1'b1, 1'b1);
    tick();
    chk("odd_cnt", err_count, 2'd1);

    // None, 0xA3: done right after the 8th bit, no parity phase.
    frame_bits(3'b000, 8'hA3, 8, 1'b0);
    chk("none_done", done, 1'b1);
    chk("none_pbit", parity_bit, 1'b1);
    chk("none_perr", parity_err, 1'b0);
    tick();
    chk("none_idle", busy, 1'b0);

    // Code 111 behaves as none.
    frame_bits(3'b111, 8'h00, 8, 1'b0);
    chk("rsv_done", done, 1'b1);
    chk("rsv_perr", parity_err, 1'b0);
    tick();

    // Mark vs space with data 0x00 and par_in=0.
    frame_bits(3'b011, 8'h00, 8, 1'b0);
    par_phase("mark", 1'b0, 1'b1, 1'b1);
    tick();
    chk("mark_cnt", err_count, 2'd2);
    frame_bits(3'b100, 8'h00, 8, 1'b0);
    par_phase("space", 1'b0, 1'b0, 1'b0);
    tick();
    chk("space_cnt", err_count, 2'd2);

    // Abort after 4 bits: no done, parity_bit held from space frame.
    frame_bits(3'b010, 8'hFF, 4, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", busy, 1'b0);
    chk("abort_nodone", done, 1'b0);
    chk("abort_pbit", parity_bit, 1'b0);
    tick();
    chk("abort_nodone2", done, 1'b0);
    frame_bits(3'b010, 8'h01, 8, 1'b0);
    par_phase("after_abort", 1'b1, 1'b1, 1'b0);
    tick();
    chk("after_abort_cnt", err_count, 2'd2);

    // start with abort in IDLE stays idle.
    parity_type = 3'b010; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 1'b0);

    // Abort during DONE is ignored.
    frame_bits(3'b001, 8'h55, 8, 1'b0);
    par_valid = 1'b1; par_in = 1'b1;
    tick();
    par_valid = 1'b0; abort = 1'b1;
    chk("abort_in_done", done, 1'b1);
    chk("abort_in_done_perr", parity_err, 1'b0);
    tick();
    abort = 1'b0;
    chk("abort_in_done_idle", busy, 1'b0);

    // Mid-frame reset discards the frame and restores parity_bit=1.
    frame_bits(3'b010, 8'h01, 8, 1'b0);
    reset_n = 1'b0; par_valid = 1'b1; par_in = 1'b0;
    tick();
    reset_n = 1'b1; par_valid = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_pbit", parity_bit, 1'b1);
    chk("midrst_cnt", err_count, 2'd0);

    // Saturation with CNT_W=2, then clear coinciding with an error done.
    for (int f = 0; f < 4; f++) begin
      frame_bits(3'b001, 8'h55, 8, 1'b0);
      par_phase("sat", 1'b0, 1'b1, 1'b1);
      tick();
      chk($sformatf("sat_cnt%0d", f), err_count, (f < 3) ? 2'(f + 1) : 2'd3);
    end
    frame_bits(3'b001, 8'h55, 8, 1'b0);
    par_phase("clr", 1'b0, 1'b1, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", err_count, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
